prefetcher_data_mstream: RTL and testbench
==========================================

Name: prefetcher_data_mstream

Overview:
- Multi-stream successor to the single-queue prefetcher data store: holds NUM_STREAMS independent circular queues of DRAM prefetch blocks, one per prefetch stream.
- Each entry tracks address, outstanding-request state and returned data.
- Sits between the stream-detection/control logic, which issues per-stream opcodes, and the AXI AR/R path.
- Adds per-stream flush, registered tagged responses and explicit error reporting for misses, pending data and bad stream IDs.

Parameters:
- NUM_STREAMS, 4, number of independent stream queues (≥1).
- LOG_STREAMS, 2, width of reqStream; must satisfy 2^LOG_STREAMS ≥ NUM_STREAMS.
- LOG_DEPTH, 3, log2 of entries per stream queue (DEPTH = 2^LOG_DEPTH).
- LOG_BLOCK_DATA_BYTES, 6, block size in bytes as log2; BLOCK_BITS = 8·2^LOG_BLOCK_DATA_BYTES.
- ADDR_BITS, 64, block address width.

Ports:
- clk, in, 1, clock.
- resetN, in, 1, asynchronous active-low reset.
- reqOpcode, in, 3, 0 NOP, 1 INVALIDATE, 2 READ, 3 WRITE_REQ, 4 WRITE_RESP, 5 FLUSH, 6/7 treated as NOP.
- reqStream, in, LOG_STREAMS, target stream ID.
- reqAddr, in, ADDR_BITS, block-aligned address.
- reqData, in, BLOCK_BITS, data for WRITE_RESP.
- crs_almostFullSpacer, in, LOG_DEPTH, almost-full margin applied to all streams.
- respValid, out, 1, registered read-data valid.
- respData, out, BLOCK_BITS, registered read data.
- respStream, out, LOG_STREAMS, stream ID of the response.
- errorCode, out, 3, registered error for the previous cycle's op.
- validCnt, out, NUM_STREAMS·(LOG_DEPTH+1), packed per-stream valid-entry count; stream s occupies bits [s·(LOG_DEPTH+1) +: LOG_DEPTH+1].
- outstandingCnt, out, NUM_STREAMS·(LOG_DEPTH+1), packed per-stream count of entries awaiting WRITE_RESP.
- almostFull, out, NUM_STREAMS, per-stream almost-full flag.
- full, out, NUM_STREAMS, per-stream full flag.

Behaviour:
- One opcode per cycle. All state and registered outputs update on posedge clk.
- respValid, respStream and errorCode default to 0 every cycle unless set by the current op. respData holds its last value when respValid=0.
- Reset (async, resetN=0): all valid, dataValid and outstanding bits, head/tail pointers, counts, respValid, respStream, respData and errorCode go to 0. The data array is not reset. Reset mid-operation discards all state; outstanding AXI returns then miss (error 5).
- Per-stream state:
  - head and tail pointers, LOG_DEPTH bits, wrapping modulo DEPTH.
  - count, LOG_DEPTH+1 bits; full = (count == DEPTH).
  - almostFull = (count + spacer ≥ DEPTH), evaluated at LOG_DEPTH+2 bits with no overflow. Both full and almostFull are combinational from registered count.
- Lookup: match reqAddr against valid entries of stream reqStream only. At most one match exists because WRITE_REQ rejects duplicates. The same address in different streams is legal.
- reqStream ≥ NUM_STREAMS with a non-NOP opcode: no state change, errorCode = 6.
- INVALIDATE:
  - Hit: clear dataValid of the entry. The entry stays allocated and outstanding is unchanged. A later WRITE_RESP refills it.
  - Miss: no-op, no error.
- READ:
  - Hit with dataValid: respValid=1, respData=entry data, respStream=reqStream, one cycle after the op. If the hit entry is the head, pop it in the same cycle (clear valid, head+1, count−1). A non-head hit responds without popping.
  - Hit without dataValid: no response, errorCode = 4 (pending).
  - Miss: errorCode = 3.
- WRITE_REQ:
  - Hit: errorCode = 1, no change.
  - Full: errorCode = 2, no change.
  - Otherwise, at tail: set valid=1, dataValid=0, outstanding=1, store addr; tail+1, count+1.
- WRITE_RESP:
  - Hit with outstanding=1: store data, set dataValid=1, clear outstanding.
  - Hit with outstanding=0: overwrite data, set dataValid=1, errorCode = 7 (unsolicited refill).
  - Miss: errorCode = 5, data dropped.
- FLUSH: clear valid, dataValid and outstanding for every entry of the stream; head=tail=count=0. Other streams are unaffected. Flushing an empty stream is legal and reports no error.
- Wrap: pointers wrap from DEPTH−1 to 0. Full and empty are distinguished only by count.
- Streams are fully independent: an op on stream a never changes any state of stream b.

Test Plan:
- Reset, then WRITE_REQ stream 1 addr 0x1000 → validCnt[1]=1, outstandingCnt[1]=1, other streams 0, errorCode=0.
- WRITE_RESP stream 1 addr 0x1000 data 0xAB.., then READ stream 1 addr 0x1000 → next cycle respValid=1, respData=0xAB.., respStream=1; validCnt[1]=0 (head popped).
- Fill stream 0 with DEPTH=8 WRITE_REQs, then a ninth → full[0]=1, errorCode=2, count stays 8. With spacer=2, almostFull[0] asserts once count reaches 6.
- READ of an allocated entry before its WRITE_RESP → errorCode=4, respValid=0. READ of absent addr → errorCode=3. Repeat WRITE_REQ of the same addr → errorCode=1. reqStream=5 with NUM_STREAMS=4 → errorCode=6.
- Enqueue 8 entries, pop 5, enqueue 5 more (tail wraps to 5) → count=8; reads in order return correct data across the wrap.
- Stream 2 with 3 outstanding entries, FLUSH stream 2 → validCnt[2]=0, outstandingCnt[2]=0; a later WRITE_RESP for one of those addresses → errorCode=5; stream 1 contents unchanged. Assert resetN mid-sequence → all counts and outputs 0 immediately.

Source files
------------

// File: rtl/prefetcher_data_mstream.sv
// Multi-stream prefetch block store. There is one circular queue per stream, with
// a registered, tagged read response and a registered per-op error code.
module prefetcher_data_mstream #(
    parameter int NUM_STREAMS          = 4,
    parameter int LOG_STREAMS          = 2,
    parameter int LOG_DEPTH            = 3,
    parameter int LOG_BLOCK_DATA_BYTES = 6,
    parameter int ADDR_BITS            = 64,
    localparam int DEPTH      = 1 << LOG_DEPTH,
    localparam int BLOCK_BITS = 8 * (1 << LOG_BLOCK_DATA_BYTES),
    localparam int CW         = LOG_DEPTH + 1
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic [2:0]                reqOpcode,
    input  logic [LOG_STREAMS-1:0]    reqStream,
    input  logic [ADDR_BITS-1:0]      reqAddr,
    input  logic [BLOCK_BITS-1:0]     reqData,
    input  logic [LOG_DEPTH-1:0]      crs_almostFullSpacer,
    output logic                      respValid,
    output logic [BLOCK_BITS-1:0]     respData,
    output logic [LOG_STREAMS-1:0]    respStream,
    output logic [2:0]                errorCode,
    output logic [NUM_STREAMS*CW-1:0] validCnt,
    output logic [NUM_STREAMS*CW-1:0] outstandingCnt,
    output logic [NUM_STREAMS-1:0]    almostFull,
    output logic [NUM_STREAMS-1:0]    full
);

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_INVALIDATE = 3'd1,
        OP_READ       = 3'd2,
        OP_WRITE_REQ  = 3'd3,
        OP_WRITE_RESP = 3'd4,
        OP_FLUSH      = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        ERR_NONE       = 3'd0,
        ERR_DUPLICATE  = 3'd1,
        ERR_FULL       = 3'd2,
        ERR_READ_MISS  = 3'd3,
        ERR_PENDING    = 3'd4,
        ERR_RESP_MISS  = 3'd5,
        ERR_BAD_STREAM = 3'd6,
        ERR_UNSOLICIT  = 3'd7
    } err_e;

    logic [DEPTH-1:0]      r_valid  [NUM_STREAMS];
    logic [DEPTH-1:0]      r_dvalid [NUM_STREAMS];
    logic [DEPTH-1:0]      r_outst  [NUM_STREAMS];
    logic [ADDR_BITS-1:0]  r_addr   [NUM_STREAMS][DEPTH];
    logic [BLOCK_BITS-1:0] r_data   [NUM_STREAMS][DEPTH];
    logic [LOG_DEPTH-1:0]  r_head   [NUM_STREAMS];
    logic [LOG_DEPTH-1:0]  r_tail   [NUM_STREAMS];
    logic [CW-1:0]         r_count  [NUM_STREAMS];

    logic                  r_respValid;
    logic [BLOCK_BITS-1:0] r_respData;
    logic [LOG_STREAMS-1:0] r_respStream;
    err_e                  r_err;

    logic                   w_sidValid;
    logic                   w_isOp;
    logic [NUM_STREAMS-1:0] w_sel;
    logic [DEPTH-1:0]       w_hitVec;
    logic                   w_hit;
    logic                   w_hitDv;
    logic                   w_hitOut;
    logic [LOG_DEPTH-1:0]   w_hitIdx;
    logic [BLOCK_BITS-1:0]  w_hitData;
    logic [CW-1:0]          w_count;
    logic                   w_full;
    logic                   w_allocate;
    logic                   w_refill;

    // Lookup is confined to the addressed stream; the same address may live in other streams.
    always_comb begin
        w_sidValid = (32'(reqStream) < NUM_STREAMS);
        w_isOp     = (reqOpcode != OP_NOP) && (reqOpcode <= OP_FLUSH);
        w_sel      = '0;
        w_hitVec   = '0;
        w_hitDv    = 1'b0;
        w_hitOut   = 1'b0;
        w_hitIdx   = '0;
        w_hitData  = '0;
        w_count    = '0;
        for (int unsigned s = 0; s < NUM_STREAMS; s++) begin
            if (w_sidValid && LOG_STREAMS'(s) == reqStream) begin
                w_sel[s] = 1'b1;
                w_count  = r_count[s];
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    if (r_valid[s][e] && r_addr[s][e] == reqAddr) begin
                        w_hitVec[e] = 1'b1;
                        w_hitIdx    = LOG_DEPTH'(e);
                        w_hitDv     = r_dvalid[s][e];
                        w_hitOut    = r_outst[s][e];
                        w_hitData   = r_data[s][e];
                    end
                end
            end
        end
        w_hit      = |w_hitVec;
        w_full     = (w_count == CW'(DEPTH));
        w_allocate = (reqOpcode == OP_WRITE_REQ) && !w_hit && !w_full;
        w_refill   = (reqOpcode == OP_WRITE_RESP) && w_hit;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int unsigned s = 0; s < NUM_STREAMS; s++) begin
                r_valid[s]  <= '0;
                r_dvalid[s] <= '0;
                r_outst[s]  <= '0;
                r_head[s]   <= '0;
                r_tail[s]   <= '0;
                r_count[s]  <= '0;
            end
            r_respValid  <= 1'b0;
            r_respData   <= '0;
            r_respStream <= '0;
            r_err        <= ERR_NONE;
        end else begin
            r_respValid  <= 1'b0;
            r_respStream <= '0;
            r_err        <= ERR_NONE;
            if (w_isOp && !w_sidValid) begin
                r_err <= ERR_BAD_STREAM;
            end
            for (int unsigned s = 0; s < NUM_STREAMS; s++) begin
                if (w_sel[s]) begin
                    case (reqOpcode)
                        OP_INVALIDATE: begin
                            if (w_hit) r_dvalid[s][w_hitIdx] <= 1'b0;
                        end
                        OP_READ: begin
                            if (!w_hit) begin
                                r_err <= ERR_READ_MISS;
                            end else if (!w_hitDv) begin
                                r_err <= ERR_PENDING;
                            end else begin
                                r_respValid  <= 1'b1;
                                r_respData   <= w_hitData;
                                r_respStream <= reqStream;
                                // Only a head hit retires the entry; deeper hits leave the queue intact.
                                if (w_hitIdx == r_head[s]) begin
                                    r_valid[s][w_hitIdx]  <= 1'b0;
                                    r_dvalid[s][w_hitIdx] <= 1'b0;
                                    r_head[s]  <= r_head[s] + 1'b1;
                                    r_count[s] <= r_count[s] - 1'b1;
                                end
                            end
                        end
                        OP_WRITE_REQ: begin
                            if (w_hit) begin
                                r_err <= ERR_DUPLICATE;
                            end else if (w_full) begin
                                r_err <= ERR_FULL;
                            end else begin
                                r_valid[s][r_tail[s]]  <= 1'b1;
                                r_dvalid[s][r_tail[s]] <= 1'b0;
                                r_outst[s][r_tail[s]]  <= 1'b1;
                                r_tail[s]  <= r_tail[s] + 1'b1;
                                r_count[s] <= r_count[s] + 1'b1;
                            end
                        end
                        OP_WRITE_RESP: begin
                            if (!w_hit) begin
                                r_err <= ERR_RESP_MISS;
                            end else begin
                                r_dvalid[s][w_hitIdx] <= 1'b1;
                                r_outst[s][w_hitIdx]  <= 1'b0;
                                if (!w_hitOut) r_err <= ERR_UNSOLICIT;
                            end
                        end
                        OP_FLUSH: begin
                            r_valid[s]  <= '0;
                            r_dvalid[s] <= '0;
                            r_outst[s]  <= '0;
                            r_head[s]   <= '0;
                            r_tail[s]   <= '0;
                            r_count[s]  <= '0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Address and data storage carry no reset; validity bits alone qualify them.
    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < NUM_STREAMS; s++) begin
            if (w_sel[s]) begin
                if (w_allocate) r_addr[s][r_tail[s]] <= reqAddr;
                if (w_refill)   r_data[s][w_hitIdx]  <= reqData;
            end
        end
    end

    always_comb begin
        validCnt       = '0;
        outstandingCnt = '0;
        almostFull     = '0;
        full           = '0;
        for (int unsigned s = 0; s < NUM_STREAMS; s++) begin
            validCnt[s*CW +: CW] = r_count[s];
            for (int unsigned e = 0; e < DEPTH; e++) begin
                outstandingCnt[s*CW +: CW] = outstandingCnt[s*CW +: CW] + CW'(r_outst[s][e]);
            end
            full[s]       = (r_count[s] == CW'(DEPTH));
            almostFull[s] = ({1'b0, r_count[s]} + {2'b00, crs_almostFullSpacer}) >= (CW+1)'(DEPTH);
        end
    end

    assign respValid  = r_respValid;
    assign respData   = r_respData;
    assign respStream = r_respStream;
    assign errorCode  = r_err;

endmodule

// File: tb/tb_prefetcher_data_mstream.sv
// Bench for prefetcher_data_mstream: directed scenarios plus random ops, checked against
// a queue-per-stream reference model.
module tb_prefetcher_data_mstream;

    localparam int NS = 4;
    localparam int LS = 3;
    localparam int BB = 512;

    logic           clk = 1'b0;
    logic           resetN;
    logic [2:0]     reqOpcode;
    logic [LS-1:0]  reqStream;
    logic [63:0]    reqAddr;
    logic [BB-1:0]  reqData;
    logic [2:0]     crs_almostFullSpacer;
    logic           respValid;
    logic [BB-1:0]  respData;
    logic [LS-1:0]  respStream;
    logic [2:0]     errorCode;
    logic [NS*4-1:0] validCnt;
    logic [NS*4-1:0] outstandingCnt;
    logic [NS-1:0]  almostFull;
    logic [NS-1:0]  full;

    prefetcher_data_mstream #(.NUM_STREAMS(NS), .LOG_STREAMS(LS), .LOG_DEPTH(3),
                              .LOG_BLOCK_DATA_BYTES(6), .ADDR_BITS(64)) dut (
        .clk(clk), .resetN(resetN), .reqOpcode(reqOpcode), .reqStream(reqStream),
        .reqAddr(reqAddr), .reqData(reqData), .crs_almostFullSpacer(crs_almostFullSpacer),
        .respValid(respValid), .respData(respData), .respStream(respStream),
        .errorCode(errorCode), .validCnt(validCnt), .outstandingCnt(outstandingCnt),
        .almostFull(almostFull), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]   a;
        logic [BB-1:0] d;
        bit            dv;
        bit            os;
    } ent_t;

    ent_t          q [NS][$];
    int            spacer;
    int            n_vec = 0;
    int            n_err = 0;
    logic [2:0]    e_err;
    bit            e_rv;
    logic [LS-1:0] e_rs;
    logic [BB-1:0] e_rd;

    task automatic chk(input string tag, input logic [BB-1:0] obs, input logic [BB-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int find(input int s, input logic [63:0] a);
        for (int i = 0; i < q[s].size(); i++) if (q[s][i].a == a) return i;
        return -1;
    endfunction

    function automatic logic [BB-1:0] rnd_data();
        logic [BB-1:0] v;
        for (int i = 0; i < BB/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) q[s].delete();
        e_err = 0; e_rv = 0; e_rs = 0; e_rd = '0;
    endtask

    task automatic model(input int o, input int s, input logic [63:0] a, input logic [BB-1:0] d);
        int   i;
        ent_t e;
        e_err = 0; e_rv = 0; e_rs = 0;
        if (o >= 1 && o <= 5 && s >= NS) begin
            e_err = 6;
            return;
        end
        if (s >= NS) return;
        i = find(s, a);
        case (o)
            1: if (i >= 0) begin e = q[s][i]; e.dv = 0; q[s][i] = e; end
            2: begin
                if (i < 0) e_err = 3;
                else if (!q[s][i].dv) e_err = 4;
                else begin
                    e_rv = 1; e_rs = LS'(s); e_rd = q[s][i].d;
                    if (i == 0) void'(q[s].pop_front());
                end
            end
            3: begin
                if (i >= 0) e_err = 1;
                else if (q[s].size() == 8) e_err = 2;
                else begin e.a = a; e.d = '0; e.dv = 0; e.os = 1; q[s].push_back(e); end
            end
            4: begin
                if (i < 0) e_err = 5;
                else begin
                    e = q[s][i];
                    if (!e.os) e_err = 7;
                    e.d = d; e.dv = 1; e.os = 0; q[s][i] = e;
                end
            end
            5: q[s].delete();
            default: ;
        endcase
    endtask

    task automatic check_all();
        int oc;
        chk("errorCode", errorCode, e_err);
        chk("respValid", respValid, e_rv);
        chk("respStream", respStream, e_rs);
        chk("respData", respData, e_rd);
        for (int s = 0; s < NS; s++) begin
            oc = 0;
            foreach (q[s][i]) if (q[s][i].os) oc++;
            chk($sformatf("validCnt[%0d]", s), validCnt[s*4 +: 4], q[s].size());
            chk($sformatf("outstandingCnt[%0d]", s), outstandingCnt[s*4 +: 4], oc);
            chk($sformatf("full[%0d]", s), full[s], q[s].size() == 8);
            chk($sformatf("almostFull[%0d]", s), almostFull[s], (q[s].size() + spacer) >= 8);
        end
    endtask

    task automatic op(input int o, input int s, input logic [63:0] a, input logic [BB-1:0] d);
        @(negedge clk);
        reqOpcode = o[2:0]; reqStream = s[LS-1:0]; reqAddr = a; reqData = d;
        crs_almostFullSpacer = spacer[2:0];
        model(o, s, a, d);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [BB-1:0] dAB;
        int o, s, r, idx;
        logic [63:0] a;

        resetN = 1'b0; reqOpcode = 0; reqStream = 0; reqAddr = 0; reqData = '0;
        spacer = 2; crs_almostFullSpacer = 3'd2;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) resetN = 1'b1;

        // Single allocate, refill and head read on stream 1
        op(3, 1, 64'h1000, '0);
        chk("dir_vcnt1", validCnt[7:4], 4'd1);
        chk("dir_ocnt1", outstandingCnt[7:4], 4'd1);
        dAB = {64{8'hAB}};
        op(4, 1, 64'h1000, dAB);
        op(2, 1, 64'h1000, '0);
        chk("dir_rdata", respData, dAB);
        chk("dir_vcnt1_pop", validCnt[7:4], 4'd0);

        // Fill stream 0 past full
        for (int i = 0; i < 9; i++) op(3, 0, 64'h2000 + 64'(i) * 64, '0);
        chk("dir_full0", full[0], 1'b1);
        chk("dir_err_full", errorCode, 3'd2);

        // Error cases: pending, read miss, duplicate, bad stream
        op(2, 0, 64'h2000, '0);
        chk("dir_pending", errorCode, 3'd4);
        op(2, 0, 64'h9000, '0);
        op(3, 0, 64'h2040, '0);
        op(3, 5, 64'h2040, '0);
        chk("dir_badstream", errorCode, 3'd6);
        op(2, 7, 64'h2040, '0);
        op(4, 0, 64'h2040, rnd_data());
        op(4, 0, 64'h2040, rnd_data());
        chk("dir_unsolicited", errorCode, 3'd7);
        op(1, 0, 64'h2040, '0);
        op(2, 0, 64'h2040, '0);
        op(5, 0, 64'h0, '0);

        // Wraparound on stream 3
        for (int i = 0; i < 8; i++) op(3, 3, 64'h4000 + 64'(i) * 64, '0);
        for (int i = 0; i < 8; i++) op(4, 3, 64'h4000 + 64'(i) * 64, rnd_data());
        for (int i = 0; i < 5; i++) op(2, 3, 64'h4000 + 64'(i) * 64, '0);
        for (int i = 0; i < 5; i++) op(3, 3, 64'h5000 + 64'(i) * 64, '0);
        for (int i = 0; i < 5; i++) op(4, 3, 64'h5000 + 64'(i) * 64, rnd_data());
        chk("dir_wrap_cnt", validCnt[15:12], 4'd8);
        for (int i = 0; i < 8; i++) op(2, 3, q[3][0].a, '0);

        // Flush isolation
        op(3, 1, 64'h6000, '0);
        op(4, 1, 64'h6000, rnd_data());
        for (int i = 0; i < 3; i++) op(3, 2, 64'h7000 + 64'(i) * 64, '0);
        op(5, 2, 64'h0, '0);
        op(4, 2, 64'h7040, rnd_data());
        chk("dir_flush_miss", errorCode, 3'd5);
        op(5, 2, 64'h0, '0);
        op(2, 1, 64'h6000, '0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if (n % 25 == 0) spacer = $urandom_range(0, 7);
            r = $urandom_range(0, 99);
            s = (r < 3) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
            r = $urandom_range(0, 99);
            if (r < 30) o = 3;
            else if (r < 55) o = 4;
            else if (r < 85) o = 2;
            else if (r < 92) o = 1;
            else if (r < 95) o = 5;
            else if (r < 98) o = 0;
            else o = $urandom_range(6, 7);
            if (s < NS && q[s].size() > 0 && $urandom_range(0, 1) == 1) begin
                idx = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, q[s].size() - 1));
                a = q[s][idx].a;
            end else begin
                a = 64'($urandom_range(0, 15)) << 6;
            end
            op(o, s, a, rnd_data());
        end

        // Asynchronous reset in the middle of activity
        op(3, 1, 64'h8000, '0);
        @(negedge clk);
        reqOpcode = 0;
        #2 resetN = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk) resetN = 1'b1;
        op(4, 1, 64'h8000, rnd_data());
        op(0, 0, 64'h0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
